seg7_scan_mux: RTL

Multiplexed 7-segment display driver, downstream of the clock divider. It consumes the divider's square-wave output as a scan-rate signal, detects its rising edges in the system clock domain, and steps through DIGITS digits. For each digit it drives an active-low anode and the active-low hex-decoded segment pattern. Sits between the clock divider / datapath and the board's display pins.

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/hex_to_seg7.sv | 14 +
 rtl/seg7_scan_mux.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver.
// Holds the active-low hex segment table, the all-dark segment constant
// and the helper that sizes the digit index counter.
// Segment bit order everywhere is {g,f,e,d,c,b,a}; a 0 lights the segment.
package seg7_pkg;

    // Active-low segment patterns for hex digits 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Every segment dark.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Width of the digit index counter; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Purely combinational hex nibble to active-low 7-segment decoder.
// Ports:
//   nibble  in  4  hex digit to display
//   seg     out 7  {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_mux.sv
// Multiplexed 7-segment display driver.
// The clock divider's square wave arrives on scan_in as plain data; it is
// synchronized into clk, rising edges become one-cycle step pulses, and each
// step moves the scan to the next digit. The displayed value and decimal
// points are taken from a shadow copy refreshed once per frame so a digit
// never shows a half-updated value.
//
// Parameters:
//   DIGITS       number of multiplexed digits (2..8)
//   SYNC_STAGES  synchronizer flops on scan_in (>= 2)
// Ports:
//   clk        in  1         system clock, the only clock in the block
//   rst        in  1         synchronous active-high reset
//   scan_in    in  1         divider output, sampled as data
//   value      in  4*DIGITS  hex nibbles, digit 0 = value[3:0]
//   dp         in  DIGITS    decimal-point request per digit, active-high
//   blank      in  1         force the display dark (synchronous to clk)
//   an         out DIGITS    anode enables, active-low
//   seg        out 7         {g,f,e,d,c,b,a}, active-low
//   dp_n       out 1         decimal point, active-low
//   digit_idx  out 3         digit currently being scanned
//
// Build option: define SEG7_LEADING_ZERO_BLANK_EN to darken leading zero
// digits (digit 0 and digits with their dp bit set always stay lit).
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_in,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic [2:0]            digit_idx
);

    localparam int IW = idx_width(DIGITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_ONE = DIGITS'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   step_q, step_d;
    logic                   first_q, first_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [4*DIGITS-1:0]    shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0]      shadow_dp_q, shadow_dp_d;
    logic [DIGITS-1:0]      an_q, an_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_n_q, dp_n_d;
    logic [3:0]             nibble;
    logic [6:0]             seg_dec;
    logic                   dark;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [IW-1:0]          msd;
`endif

    // Synchronizer shift chain plus edge detector. The step pulse is itself
    // registered, so it is glitch-free and lands one cycle after the
    // synchronized rising edge.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], scan_in};
        prev_d = sync_q[SYNC_STAGES-1];
        step_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    // Digit sequencing and frame latch. The first step after reset starts
    // the scan on digit 0 rather than advancing past it; that step and every
    // wrap back to digit 0 refresh the shadow copy of value and dp.
    always_comb begin
        idx_d        = idx_q;
        first_d      = first_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        if (step_q) begin
            first_d = 1'b0;
            if (first_q || idx_q == LAST_IDX) begin
                idx_d        = '0;
                shadow_val_d = value;
                shadow_dp_d  = dp;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    assign nibble = shadow_val_d[4*int'(idx_d) +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    // Output drive for the digit being entered. The display stays dark
    // until the first step so nothing flashes while the divider starts up.
    always_comb begin
        dark = blank | first_d;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        msd = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (shadow_val_d[4*i +: 4] != 4'h0) begin
                msd = IW'(i);
            end
        end
        if (idx_d > msd && !shadow_dp_d[idx_d]) begin
            dark = 1'b1;
        end
`endif
        if (dark) begin
            an_d   = '1;
            seg_d  = SEG_OFF;
            dp_n_d = 1'b1;
        end else begin
            an_d   = ~(AN_ONE << idx_d);
            seg_d  = seg_dec;
            dp_n_d = ~shadow_dp_d[idx_d];
        end
    end

    // State registers; reset also discards any step in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            prev_q       <= 1'b0;
            step_q       <= 1'b0;
            first_q      <= 1'b1;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
            dp_n_q       <= 1'b1;
        end else begin
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            step_q       <= step_d;
            first_q      <= first_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_n_q       <= dp_n_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp_n      = dp_n_q;
    assign digit_idx = 3'(idx_q);

endmodule
